// File: rtl/serial_pkg.sv
// Shared types and defaults for the byte-serial UART transmitter.
package serial_pkg;

  localparam int unsigned DEFAULT_CLOCKS_PER_BAUD = 104;
  localparam int unsigned DEFAULT_GAP_CLOCKS      = 4;
  localparam int unsigned BAUD_CNT_W              = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StGap
  } state_e;

endpackage

// File: rtl/baud_timer.sv
// Reloadable down-counter: ticks when it reaches zero, then reloads to period-1.
module baud_timer
  import serial_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [BAUD_CNT_W-1:0] i_period,
  output logic                  o_tick
);

  logic [BAUD_CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    o_tick  = 1'b0;
    if (i_load) begin
      count_d = i_period - BAUD_CNT_W'(1);
    end else if (count_q == '0) begin
      o_tick  = 1'b1;
      count_d = i_period - BAUD_CNT_W'(1);
    end else begin
      count_d = count_q - BAUD_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// 8N1 UART transmitter: latches a byte from the source, pulses o_get_next,
// shifts the byte out LSB first, then holds the line idle for a settling gap.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
  parameter int unsigned GAP_CLOCKS      = DEFAULT_GAP_CLOCKS
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [7:0] i_data,
  output logic       o_get_next,
  output logic       o_busy,
  output logic       o_tx
);

  localparam logic [BAUD_CNT_W-1:0] Period  = BAUD_CNT_W'(CLOCKS_PER_BAUD);
  localparam logic [7:0]            GapLast = 8'(GAP_CLOCKS - 1);

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       tx_q, tx_d;
  logic       get_next_q, get_next_d;
  logic       baud_load;
  logic       baud_tick;

  baud_timer u_baud_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (baud_load),
    .i_period (Period),
    .o_tick   (baud_tick)
  );

  // tx_d is the line level for the state being entered, so o_tx stays registered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    gap_cnt_d  = gap_cnt_q;
    tx_d       = tx_q;
    get_next_d = 1'b0;
    baud_load  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (i_enable) begin
          shift_d    = i_data;
          get_next_d = 1'b1;
          baud_load  = 1'b1;
          tx_d       = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (baud_tick) begin
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = StData;
        end
      end
      StData: begin
        if (baud_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (baud_tick) begin
          gap_cnt_d = GapLast;
          tx_d      = 1'b1;
          state_d   = StGap;
        end
      end
      StGap: begin
        tx_d = 1'b1;
        if (gap_cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      gap_cnt_q  <= '0;
      tx_q       <= 1'b1;
      get_next_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_q       <= tx_d;
      get_next_q <= get_next_d;
    end
  end

  assign o_tx       = tx_q;
  assign o_get_next = get_next_q;
  assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx (N=4, G=2): expected bytes are queued when driven
// and popped when a frame is checked or decoded from the line.
module tb_serial_tx;

  localparam int N     = 4;
  localparam int G     = 2;
  localparam int FRAME = 10 * N + G + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] tb_data;
  logic [7:0] dut_data;
  logic       gn;
  logic       busy;
  logic       tx;

  logic [7:0] msg [14];
  int         src_idx = 0;
  bit         src_mode = 1'b0;
  bit         src_clr = 1'b0;
  logic       gn_d1 = 1'b0;

  int         n_pass = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         gn_cnt = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  serial_tx #(
    .CLOCKS_PER_BAUD (N),
    .GAP_CLOCKS      (G)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_enable   (en),
    .i_data     (dut_data),
    .o_get_next (gn),
    .o_busy     (busy),
    .o_tx       (tx)
  );

  // Byte source model: output advances two clocks after o_get_next.
  assign dut_data = src_mode ? msg[src_idx] : tb_data;
  always @(posedge clk) begin
    gn_d1 <= gn;
    if (src_clr) src_idx <= 0;
    else if (gn_d1) src_idx <= (src_idx == 13) ? 0 : src_idx + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (gn === 1'b1) gn_cnt++;
  endtask

  // Entered in frame cycle 0 (IDLE, enable high); checks cycles 1..FRAME.
  task automatic frame_body(input int drop_at);
    logic [7:0] b;
    logic       exp_tx;
    b = 8'h00;
    chk("queue not empty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) b = exp_q.pop_front();
    for (int c = 1; c <= FRAME; c++) begin
      step();
      if (c <= N) exp_tx = 1'b0;
      else if (c <= 9 * N) exp_tx = b[(c - N - 1) / N];
      else exp_tx = 1'b1;
      chk($sformatf("tx %02h c%0d", b, c), 32'(tx), 32'(exp_tx));
      chk($sformatf("get_next %02h c%0d", b, c), 32'(gn), 32'(c == 1));
      chk($sformatf("busy %02h c%0d", b, c), 32'(busy), 32'(c < FRAME));
      if (c == drop_at) en = 1'b0;
      if (c == 2) tb_data = ~tb_data;
    end
  endtask

  task automatic do_frame(input logic [7:0] b);
    tb_data = b;
    en      = 1'b1;
    exp_q.push_back(b);
    frame_body(1);
  endtask

  task automatic recv_byte(output logic [7:0] b, output int s);
    int w;
    w = 0;
    b = 8'h00;
    while (tx !== 1'b0 && w < 100) begin
      step();
      w++;
    end
    s = cyc;
    if (tx !== 1'b0) begin
      chk("rx start timeout", 32'(tx), 32'd0);
      return;
    end
    for (int k = 0; k < 8; k++) begin
      while (cyc < s + N * (k + 1) + N / 2) step();
      b[k] = tx;
    end
    while (cyc < s + 9 * N + N / 2) step();
    chk("rx stop bit", 32'(tx), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string      hello;
    logic [7:0] got;
    logic [7:0] want;
    int         s;
    int         prev_s;
    int         w;

    hello = "Hello, world!";
    for (int i = 0; i < 13; i++) msg[i] = hello[i];
    msg[13] = 8'h00;

    rst = 1'b1; en = 1'b0; tb_data = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle tx", 32'(tx), 32'd1);
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle get_next", 32'(gn), 32'd0);
    end

    do_frame(8'h48);

    // Streaming from the byte source, two full messages.
    for (int k = 0; k < 28; k++) exp_q.push_back(msg[k % 14]);
    src_clr = 1'b1;
    step();
    src_clr = 1'b0; src_mode = 1'b1; en = 1'b1; gn_cnt = 0;
    prev_s = 0;
    for (int k = 0; k < 28; k++) begin
      recv_byte(got, s);
      want = 8'h00;
      if (exp_q.size() > 0) want = exp_q.pop_front();
      chk($sformatf("stream byte %0d", k), 32'(got), 32'(want));
      if (k > 0) chk($sformatf("stream spacing %0d", k), 32'(s - prev_s), 32'(FRAME));
      prev_s = s;
      if (k == 13) chk("get_next per message", 32'(gn_cnt), 32'd14);
    end
    chk("get_next two messages", 32'(gn_cnt), 32'd28);
    en = 1'b0;
    w = 0;
    while (busy !== 1'b0 && w < 200) begin
      step();
      w++;
    end
    chk("stream drains", 32'(busy), 32'd0);
    chk("stream queue empty", 32'(exp_q.size()), 32'd0);
    src_mode = 1'b0;

    do_frame(8'hFF);
    do_frame(8'h00);

    // Reset in the middle of DATA.
    tb_data = 8'hA5; en = 1'b1;
    step();
    en = 1'b0;
    while (cyc % 1000 == 0 && 1'b0) step();
    for (int c = 2; c <= 20; c++) step();
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid-reset tx", 32'(tx), 32'd1);
    chk("mid-reset busy", 32'(busy), 32'd0);
    chk("mid-reset get_next", 32'(gn), 32'd0);
    do_frame(8'hA5);

    // Reset and enable together: reset wins.
    rst = 1'b1; en = 1'b1; tb_data = 8'h5A;
    step();
    chk("rst+en get_next", 32'(gn), 32'd0);
    chk("rst+en busy", 32'(busy), 32'd0);
    chk("rst+en tx", 32'(tx), 32'd1);
    rst = 1'b0; en = 1'b0;
    step();

    // Enable dropped at cycle 10: frame finishes, nothing further.
    tb_data = 8'h3C; en = 1'b1;
    exp_q.push_back(8'h3C);
    frame_body(10);
    gn_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      chk("post-drop tx", 32'(tx), 32'd1);
      chk("post-drop busy", 32'(busy), 32'd0);
    end
    chk("post-drop get_next count", 32'(gn_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
